// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the FSM encoding, the NOP constant and the PC/word-address widths.
package if_stage_pkg;

    localparam int PC_W    = 11;
    localparam int WADDR_W = 9;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: sequential fetch from a synchronous-read imem,
// with stall hold, decode redirect and run gating.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 11'h000,
    parameter logic [31:0]     NOP_INST = NOP_INST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               stall,
    input  logic               jump_valid,
    input  logic [PC_W-1:0]    jump_addr,
    output logic [WADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [PC_W-1:0]    pc_out,
    output logic [31:0]        inst_out,
    output logic               inst_valid,
    output logic               wist
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  f_q, f_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             vld_q, vld_d;
    logic             hold_q, hold_d;
    logic [31:0]      hold_inst_q, hold_inst_d;
    logic [31:0]      inst_cur;
    logic [1:0]       unused_jump_lsb;

    assign unused_jump_lsb = jump_addr[1:0];

    // While holding, imem_rdata already carries the next word, so the
    // presented instruction must come from the hold register.
    always_comb begin
        inst_cur = NOP_INST;
        if (vld_q) begin
            inst_cur = hold_q ? hold_inst_q : imem_rdata;
        end
    end

    assign imem_addr  = f_q[PC_W-1:2];
    assign pc_out     = pc_q;
    assign inst_out   = inst_cur;
    assign inst_valid = vld_q;
    assign wist       = ~vld_q;

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        pc_d        = pc_q;
        vld_d       = vld_q;
        hold_d      = hold_q;
        hold_inst_d = hold_inst_q;
        if (!run) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            hold_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FILL;
                    vld_d   = 1'b0;
                    hold_d  = 1'b0;
                end
                S_FILL, S_RUN: begin
                    state_d = S_RUN;
                    if (jump_valid && vld_q) begin
                        state_d = S_FILL;
                        f_d     = {jump_addr[PC_W-1:2], 2'b00};
                        vld_d   = 1'b0;
                        hold_d  = 1'b0;
                    end else if (stall) begin
                        hold_d      = vld_q;
                        hold_inst_d = inst_cur;
                    end else begin
                        f_d    = f_q + 11'd4;
                        pc_d   = f_q;
                        vld_d  = 1'b1;
                        hold_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                    hold_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            f_q         <= RESET_PC;
            pc_q        <= RESET_PC;
            vld_q       <= 1'b0;
            hold_q      <= 1'b0;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            pc_q        <= pc_d;
            vld_q       <= vld_d;
            hold_q      <= hold_d;
            hold_inst_q <= hold_inst_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage against a synchronous-read imem model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        jump_valid = 1'b0;
    logic [10:0] jump_addr = '0;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [10:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        wist;

    logic [31:0] mem [512];

    typedef struct {
        logic        v;
        logic [10:0] pc;
        logic        chk_pc;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .stall      (stall),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .wist       (wist)
    );

    // Garbage on stalled cycles: the held instruction must not track imem.
    always @(posedge clk)
        imem_rdata <= stall ? 32'hDEAD_BEEF : mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("valid", 32'(inst_valid), 32'(e.v));
            chk("wist", 32'(wist), 32'(!e.v));
            if (e.v || e.chk_pc)
                chk("pc", 32'(pc_out), 32'(e.pc));
            if (e.v)
                chk("inst", inst_out, 32'h1000_0000 + 32'(e.pc[10:2]));
            else
                chk("nop", inst_out, 32'h0000_0013);
        end
    end

    task automatic step(input logic r, input logic ru, input logic st,
                        input logic jv, input logic [10:0] ja,
                        input logic ev, input logic [10:0] epc,
                        input logic cp = 1'b0);
        exp_t e;
        @(negedge clk);
        #1;
        rst        = r;
        run        = ru;
        stall      = st;
        jump_valid = jv;
        jump_addr  = ja;
        e.v      = ev;
        e.pc     = epc;
        e.chk_pc = cp;
        sbq.push_back(e);
    endtask

    task automatic adv(input logic ev, input logic [10:0] epc);
        step(1'b0, 1'b1, 1'b0, 1'b0, 11'h0, ev, epc);
    endtask

    initial begin
        for (int i = 0; i < 512; i++)
            mem[i] = 32'h1000_0000 + 32'(i);

        // reset, then one FILL bubble and sequential fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h000, 1'b1);
        adv(1'b0, 11'h000);
        adv(1'b1, 11'h000);
        adv(1'b1, 11'h004);
        adv(1'b1, 11'h008);

        // 3-cycle stall on 0x008
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 11'h0, 1'b1, 11'h008);
        adv(1'b1, 11'h00C);
        adv(1'b1, 11'h010);

        // redirect to 0x103; a jump during the bubble is ignored
        step(1'b0, 1'b1, 1'b0, 1'b1, 11'h103, 1'b0, 11'h000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 11'h300, 1'b1, 11'h100);
        adv(1'b1, 11'h104);

        // redirect together with stall
        step(1'b0, 1'b1, 1'b1, 1'b1, 11'h200, 1'b0, 11'h000);
        adv(1'b1, 11'h200);
        adv(1'b1, 11'h204);

        // run drop and resume
        step(1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h000);
        adv(1'b0, 11'h000);
        adv(1'b1, 11'h208);

        // wrap at the top of the PC space
        step(1'b0, 1'b1, 1'b0, 1'b1, 11'h7F8, 1'b0, 11'h000);
        adv(1'b1, 11'h7F8);
        adv(1'b1, 11'h7FC);
        adv(1'b1, 11'h000);
        adv(1'b1, 11'h004);

        // reset overrides stall and jump
        step(1'b1, 1'b1, 1'b1, 1'b1, 11'h400, 1'b0, 11'h000, 1'b1);
        adv(1'b0, 11'h000);
        adv(1'b1, 11'h000);
        adv(1'b1, 11'h004);

        @(negedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 11'h000: byte PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h00000013: instruction driven on inst_out when no valid instruction is presented.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 run  input  1  fetch enable; low holds the stage idle.
REQ-006 stall  input  1  hazard hold from downstream; freezes presented instruction.
REQ-007 jump_valid  input  1  redirect request from decode for the instruction currently presented.
REQ-008 jump_addr  input  11  byte redirect target; bits [1:0] ignored.
REQ-009 imem_addr  output  9  word address to instruction memory (fetch PC [10:2]).
REQ-010 imem_rdata  input  32  instruction memory data; synchronous read, valid one cycle after imem_addr.
REQ-011 pc_out  output  11  byte PC of the presented instruction.
REQ-012 inst_out  output  32  presented instruction.
REQ-013 inst_valid  output  1  presented instruction is real, on-path.
REQ-014 wist  output  1  bubble flag to decode, equal to ~inst_valid.

Function
REQ-015 State machine states: IDLE, FILL, RUN; IDLE->FILL when run=1; FILL->RUN after exactly one cycle; any state->IDLE when run=0; RUN->FILL on accepted redirect.
REQ-016 Fetch PC (F) is 11-bit byte address; imem_addr = F[10:2] combinationally.
REQ-017 In FILL and RUN with stall=0, F advances by 4 each cycle; 11'h7FC+4 wraps to 11'h000.
REQ-018 Fetch latency: the instruction at F is presented on inst_out/pc_out one cycle after F is on imem_addr.
REQ-019 inst_valid=0 and inst_out=NOP_INST in IDLE, in FILL, and in the cycle after an accepted redirect.
REQ-020 stall=1 in cycle t: pc_out, inst_out and inst_valid at t+1 equal their values at t; F does not advance.
REQ-021 After stall drops, the instruction stream resumes with no lost and no duplicated instruction, regardless of imem_rdata changing during the stall.
REQ-022 jump_valid=1 in cycle t with inst_valid=1: F at t+1 = {jump_addr[10:2],2'b00}; t+1 is a bubble; target instruction presented with inst_valid=1 at t+2.
REQ-023 jump_valid is ignored while inst_valid=0.
REQ-024 Priority: rst > run=0 > jump_valid > stall > sequential advance; jump_valid with stall=1 is accepted and cancels the stall hold.
REQ-025 Wrong-path instruction in flight at a redirect is never presented with inst_valid=1.
REQ-026 run falling: next cycle inst_valid=0; on re-enable, fetch resumes at the byte PC of the first instruction not yet presented with inst_valid=1.

Reset
REQ-027 Reset values: state=IDLE, F=RESET_PC, pc_out=RESET_PC, inst_out=NOP_INST, inst_valid=0, wist=1, stall-hold storage cleared.
REQ-028 rst asserted mid-operation overrides run, stall and jump_valid in the same cycle.

Structure
REQ-029 Shared package holds the FSM state encoding, the default NOP constant (32'h00000013) and PC/word-address widths (11, 9).
REQ-030 Single module; no sub-module; instruction memory is external.

Verification
REQ-031 Reset, run=1, imem holds word i = 32'h1000_0000+i: pc_out 0x000,0x004,0x008 on consecutive cycles after one FILL bubble, inst_out matches words 0,1,2.
REQ-032 stall=1 for 3 cycles while pc_out=0x008: pc_out/inst_out held for 3 cycles, then 0x00C presented next, no repeat or skip.
REQ-033 jump_valid=1, jump_addr=0x103 while pc_out=0x010: next cycle inst_valid=0, inst_out=0x00000013; following cycle pc_out=0x100, inst_out=word 64.
REQ-034 F reaches 0x7FC: pc_out 0x7FC followed by 0x000 with valid data.
REQ-035 jump_valid and stall both high in one cycle: redirect taken, bubble, target presented; no stalled instruction re-presented.
REQ-036 rst pulsed while stall=1 and jump_valid=1: next cycle all outputs at REQ-027 reset values.
